// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the execute-stage ALU.
// Optional carry/overflow flag: define ALU_MUL_OVF_EN to add the ovf port.
module alu_mul_seq #(
    parameter int W   = 8,
    parameter int Ops = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [Ops-1:0] alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_zero,
    input  logic           alu_sign
`ifdef ALU_MUL_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_SHR = Ops'(1);
    localparam logic [Ops-1:0] OP_SHL = Ops'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [Ops-1:0] alu_op_q, alu_op_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load;

`ifdef ALU_MUL_OVF_EN
    logic           ovf_q, ovf_d;
    logic           lost_msb_q, lost_msb_d;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        load     = start && (state_q == S_IDLE || state_q == S_DONE);

        unique case (state_q)
            S_ADD: begin
                acc_d   = alu_out;
                state_d = S_SHL;
            end
            S_SHL: begin
                mcand_d = alu_out;
                state_d = S_SHR;
            end
            S_SHR: begin
                mplier_d = alu_out;
                if (alu_zero)      state_d = S_DONE;
                else if (alu_sign) state_d = S_ADD;
                else               state_d = S_SHL;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            acc_d    = '0;
            mcand_d  = a_in;
            mplier_d = b_in;
            if (b_in == '0)  state_d = S_DONE;
            else if (b_in[0]) state_d = S_ADD;
            else             state_d = S_SHL;
        end
    end

    // ALU drive is registered from the next-state view so it is valid
    // for the whole cycle the FSM sits in the matching state.
    always_comb begin
        alu_op_d = OP_ADD;
        alu_a_d  = '0;
        alu_b_d  = '0;
        unique case (state_d)
            S_ADD: begin
                alu_a_d = acc_d;
                alu_b_d = mcand_d;
            end
            S_SHL: begin
                alu_op_d = OP_SHL;
                alu_a_d  = mcand_d;
                alu_b_d  = W'(1);
            end
            S_SHR: begin
                alu_op_d = OP_SHR;
                alu_a_d  = mplier_d;
                alu_b_d  = W'(1);
            end
            default: ;
        endcase
        busy_d   = (state_d == S_ADD) || (state_d == S_SHL)
                || (state_d == S_SHR);
        done_d   = (state_d == S_DONE);
        result_d = done_d ? acc_d : result_q;
    end

`ifdef ALU_MUL_OVF_EN
    always_comb begin
        lost_msb_d = lost_msb_q;
        ovf_d      = ovf_q;
        if (state_q == S_SHL && mcand_q[W-1]) lost_msb_d = 1'b1;
        if (state_q == S_ADD && (alu_out < acc_q || lost_msb_q)) ovf_d = 1'b1;
        if (load) begin
            lost_msb_d = 1'b0;
            ovf_d      = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            result_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_ADD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_MUL_OVF_EN
            ovf_q      <= 1'b0;
            lost_msb_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            result_q   <= result_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef ALU_MUL_OVF_EN
            ovf_q      <= ovf_d;
            lost_msb_q <= lost_msb_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
`ifdef ALU_MUL_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: arithmetic reference model plus directed vectors.
// Builds with or without ALU_MUL_OVF_EN.
module tb_alu_mul_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a_in, b_in;
    logic       busy, done;
    logic [7:0] result, alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       alu_zero, alu_sign;
`ifdef ALU_MUL_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.W(8), .Ops(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .alu_sign (alu_sign)
`ifdef ALU_MUL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    // The CPU ALU the sequencer borrows.
    always_comb begin
        case (alu_op)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a >> alu_b;
            3'b010:  alu_out = alu_a << alu_b;
            3'b011:  alu_out = alu_a ^ alu_b;
            default: alu_out = 8'd0;
        endcase
    end
    assign alu_zero = (alu_out == 8'd0);
    assign alu_sign = alu_out[0];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int latency(input logic [7:0] b);
        int k = 0;
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                k = i + 1;
                p++;
            end
        end
        return 2 * k + p + 1;
    endfunction

    // Reference model: one operation in flight, timed by its closed-form latency.
    int          m_st = -100;
    int          m_dn = -100;
    logic [7:0]  m_prod = 8'd0;
    logic [7:0]  m_res = 8'd0;
    logic        m_ovf = 1'b0;
    logic        m_ovf_res = 1'b0;
    logic [15:0] full;

    always @(posedge clk) begin
        if (reset) begin
            m_st      = -100;
            m_dn      = -100;
            m_res     = 8'd0;
            m_ovf_res = 1'b0;
        end else if (start && !(cyc > m_st && cyc < m_dn)) begin
            full   = 16'(a_in) * 16'(b_in);
            m_prod = full[7:0];
            m_ovf  = (full > 16'd255);
            m_st   = cyc;
            m_dn   = cyc + latency(b_in);
        end
        cyc++;
        if (cyc == m_dn) begin
            m_res     = m_prod;
            m_ovf_res = m_ovf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (cyc > m_st && cyc < m_dn)});
            check("done", {31'd0, done}, {31'd0, (cyc == m_dn)});
            check("result", {24'd0, result}, {24'd0, m_res});
`ifdef ALU_MUL_OVF_EN
            if (cyc == m_dn) check("ovf", {31'd0, ovf}, {31'd0, m_ovf_res});
`endif
        end
    end

    // Drive one request and wait for its done pulse; optional re-start poke
    // while busy and optional opcode trace for the first eight busy cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input int el,
                          input logic eo, input int poke,
                          input bit trace, input logic [23:0] ops);
        int  t0;
        bit  seen;
        int  d;
        logic [2:0] eop;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            d = cyc - t0;
            if (trace && d >= 1 && d <= 8) begin
                eop = ops[3*(8-d) +: 3];
                check("trace_op", {29'd0, alu_op}, {29'd0, eop});
            end
            if (done) begin
                seen = 1;
            end else begin
                start = (poke != 0 && d == poke);
                if (start) begin
                    a_in = 8'd1;
                    b_in = 8'd1;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("lat", cyc - t0, el);
            check("res_lit", {24'd0, result}, {24'd0, er});
`ifdef ALU_MUL_OVF_EN
            check("ovf_lit", {31'd0, ovf}, {31'd0, eo});
`else
            if (eo === 1'bx) $display("unexpected X flag");
`endif
        end
    endtask

    int t0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_op", {29'd0, alu_op}, 32'd0);
        check("rst_a", {24'd0, alu_a}, 32'd0);
        check("rst_b", {24'd0, alu_b}, 32'd0);
`ifdef ALU_MUL_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle_op", {29'd0, alu_op}, 32'd0);
        check("idle_a", {24'd0, alu_a}, 32'd0);

        // ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR
        run_op(8'd3, 8'd5, 8'd15, 9, 1'b0, 0, 1'b1,
               {3'd0, 3'd2, 3'd1, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1});
        @(negedge clk);
        run_op(8'd200, 8'd0, 8'd0, 1, 1'b0, 0, 1'b0, 24'd0);
        @(negedge clk);
        run_op(8'd16, 8'd20, 8'd64, 13, 1'b1, 0, 1'b0, 24'd0);
        run_op(8'd15, 8'd17, 8'd255, 13, 1'b0, 0, 1'b0, 24'd0);
        @(negedge clk);
        run_op(8'd7, 8'd9, 8'd63, 11, 1'b0, 3, 1'b0, 24'd0);
        @(negedge clk);

        a_in  = 8'd255;
        b_in  = 8'd255;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && cyc - t0 < 4; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        run_op(8'd2, 8'd3, 8'd6, 7, 1'b0, 0, 1'b0, 24'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
